// File: rtl/riscv_core_pipe_muxnx1.sv
// N:1 operand-select pipeline stage: picks one of NUM_IN sources and registers it
// behind a valid/ready handshake with a 2-entry skid buffer and synchronous flush.
module riscv_core_pipe_muxnx1 #(
   parameter  int XLEN   = 32,
   parameter  int NUM_IN = 4,
   localparam int SEL_W  = $clog2(NUM_IN)
) (
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NUM_IN*XLEN-1:0] i_muxnx1_in,
   input  logic [SEL_W-1:0]       i_muxnx1_sel,
   input  logic                   i_muxnx1_valid,
   output logic                   o_muxnx1_ready,
   input  logic                   i_muxnx1_flush,
   output logic [XLEN-1:0]        o_muxnx1_out,
   output logic [SEL_W-1:0]       o_muxnx1_sel,
   output logic                   o_muxnx1_err,
   output logic                   o_muxnx1_valid,
   input  logic                   i_muxnx1_ready
);

   typedef struct packed {
      logic [XLEN-1:0]  word;
      logic [SEL_W-1:0] sel;
      logic             err;
   } beat_t;

   typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_TWO
   } state_e;

   state_e state_q;
   beat_t  head_q;
   beat_t  skid_q;
   logic   valid_q;
   logic   ready_q;
   beat_t  beat_in;
   logic   acc;
   logic   dlv;

   assign acc = i_muxnx1_valid & ready_q;
   assign dlv = valid_q & i_muxnx1_ready;

   // Out-of-range selects (non-power-of-2 NUM_IN) yield a zero word flagged as error.
   always_comb begin
      // NOTE: every field gets a default before the loop so no latch is inferred.
      beat_in.word = '0;
      beat_in.sel  = i_muxnx1_sel;
      beat_in.err  = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (int'(i_muxnx1_sel) == k) begin
            beat_in.word = i_muxnx1_in[k*XLEN +: XLEN];
            beat_in.err  = 1'b0;
         end
      end
   end

   // valid/ready are kept as their own flops so the outputs never decode state.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         // NOTE: head and skid are two plain registers, so clearing them on reset is
         // cheap and keeps the outputs at a known zero after reset.
         state_q <= ST_EMPTY;
         head_q  <= '0;
         skid_q  <= '0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else if (i_muxnx1_flush) begin
         state_q <= ST_EMPTY;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments so every register samples pre-edge values.
         case (state_q)
            ST_EMPTY: begin
               if (acc) begin
                  head_q  <= beat_in;
                  state_q <= ST_ONE;
                  valid_q <= 1'b1;
                  ready_q <= 1'b1;
               end
            end
            ST_ONE: begin
               if (acc && dlv) begin
                  head_q <= beat_in;
               end else if (acc) begin
                  skid_q  <= beat_in;
                  state_q <= ST_TWO;
                  ready_q <= 1'b0;
               end else if (dlv) begin
                  state_q <= ST_EMPTY;
                  valid_q <= 1'b0;
               end
            end
            ST_TWO: begin
               if (dlv) begin
                  head_q  <= skid_q;
                  state_q <= ST_ONE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_EMPTY;
               valid_q <= 1'b0;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign o_muxnx1_ready = ready_q;
   assign o_muxnx1_valid = valid_q;
   assign o_muxnx1_out   = head_q.word;
   assign o_muxnx1_sel   = head_q.sel;
   assign o_muxnx1_err   = head_q.err;

endmodule

// File: tb/tb_riscv_core_pipe_muxnx1.sv
// Bench for riscv_core_pipe_muxnx1: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_riscv_core_pipe_muxnx1;

   localparam int XLEN   = 32;
   localparam int NUM_IN = 5;
   localparam int SEL_W  = $clog2(NUM_IN);

   typedef struct {
      logic [XLEN-1:0]  word;
      logic [SEL_W-1:0] sel;
      logic             err;
   } beat_t;

   logic                   i_clk;
   logic                   i_rst_n;
   logic [NUM_IN*XLEN-1:0] i_muxnx1_in;
   logic [SEL_W-1:0]       i_muxnx1_sel;
   logic                   i_muxnx1_valid;
   logic                   o_muxnx1_ready;
   logic                   i_muxnx1_flush;
   logic [XLEN-1:0]        o_muxnx1_out;
   logic [SEL_W-1:0]       o_muxnx1_sel;
   logic                   o_muxnx1_err;
   logic                   o_muxnx1_valid;
   logic                   i_muxnx1_ready;

   beat_t q[$];
   int    n_tests;
   int    n_fail;

   riscv_core_pipe_muxnx1 #(.XLEN(XLEN), .NUM_IN(NUM_IN)) dut (
      .i_clk          (i_clk),
      .i_rst_n        (i_rst_n),
      .i_muxnx1_in    (i_muxnx1_in),
      .i_muxnx1_sel   (i_muxnx1_sel),
      .i_muxnx1_valid (i_muxnx1_valid),
      .o_muxnx1_ready (o_muxnx1_ready),
      .i_muxnx1_flush (i_muxnx1_flush),
      .o_muxnx1_out   (o_muxnx1_out),
      .o_muxnx1_sel   (o_muxnx1_sel),
      .o_muxnx1_err   (o_muxnx1_err),
      .o_muxnx1_valid (o_muxnx1_valid),
      .i_muxnx1_ready (i_muxnx1_ready)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", tag, $time, got, exp);
      end
   endtask

   function automatic beat_t model_beat(input logic [SEL_W-1:0] s, input logic [NUM_IN*XLEN-1:0] din);
      beat_t b;
      b.sel = s;
      if (int'(s) < NUM_IN) begin
         b.word = XLEN'(din >> (int'(s) * XLEN));
         b.err  = 1'b0;
      end else begin
         b.word = '0;
         b.err  = 1'b1;
      end
      return b;
   endfunction

   function automatic logic [NUM_IN*XLEN-1:0] rand_din();
      logic [NUM_IN*XLEN-1:0] d;
      for (int k = 0; k < NUM_IN; k++) d[k*XLEN +: XLEN] = $urandom;
      return d;
   endfunction

   function automatic logic [NUM_IN*XLEN-1:0] fill_din(input logic [XLEN-1:0] w);
      logic [NUM_IN*XLEN-1:0] d;
      for (int k = 0; k < NUM_IN; k++) d[k*XLEN +: XLEN] = w;
      return d;
   endfunction

   task automatic check_outputs();
      check("valid", 32'(o_muxnx1_valid), 32'(q.size() != 0));
      check("ready", 32'(o_muxnx1_ready), 32'(q.size() < 2));
      if (q.size() != 0) begin
         check("out", o_muxnx1_out, q[0].word);
         check("sel", 32'(o_muxnx1_sel), 32'(q[0].sel));
         check("err", 32'(o_muxnx1_err), 32'(q[0].err));
      end
   endtask

   // One clock: drive inputs, advance the model at the edge, then compare; inputs are
   // then scrambled mid-cycle and outputs re-checked to catch input->output paths.
   task automatic cycle(input logic v, input logic [SEL_W-1:0] s,
                        input logic [NUM_IN*XLEN-1:0] din, input logic r, input logic f);
      beat_t b;
      bit    acc;
      bit    dlv;
      i_muxnx1_valid = v;
      i_muxnx1_sel   = s;
      i_muxnx1_in    = din;
      i_muxnx1_ready = r;
      i_muxnx1_flush = f;
      acc = v && (q.size() < 2);
      dlv = (q.size() != 0) && r;
      b   = model_beat(s, din);
      @(posedge i_clk);
      if (f) begin
         q.delete();
      end else begin
         if (dlv) void'(q.pop_front());
         if (acc) q.push_back(b);
      end
      #1;
      check_outputs();
      i_muxnx1_valid = 1'($urandom);
      i_muxnx1_sel   = SEL_W'($urandom);
      i_muxnx1_in    = rand_din();
      i_muxnx1_ready = 1'($urandom);
      i_muxnx1_flush = 1'($urandom);
      #1;
      check_outputs();
   endtask

   initial begin
      logic [NUM_IN*XLEN-1:0] din;
      n_tests = 0;
      n_fail  = 0;
      i_rst_n        = 1'b0;
      i_muxnx1_in    = '0;
      i_muxnx1_sel   = '0;
      i_muxnx1_valid = 1'b0;
      i_muxnx1_ready = 1'b0;
      i_muxnx1_flush = 1'b0;
      #12;
      check_outputs();
      check("rst_out", o_muxnx1_out, 32'h0);
      check("rst_sel", 32'(o_muxnx1_sel), 32'h0);
      check("rst_err", 32'(o_muxnx1_err), 32'h0);
      i_rst_n = 1'b1;

      // Asynchronous reset while two beats are held and a third is offered.
      cycle(1'b1, 3'd1, rand_din(), 1'b0, 1'b0);
      cycle(1'b1, 3'd3, rand_din(), 1'b0, 1'b0);
      i_muxnx1_valid = 1'b1;
      i_muxnx1_flush = 1'b0;
      #1 i_rst_n = 1'b0;
      #1 q.delete();
      check_outputs();
      check("arst_out", o_muxnx1_out, 32'h0);
      check("arst_err", 32'(o_muxnx1_err), 32'h0);
      i_rst_n = 1'b1;
      #1;
      din = '0;
      din[2*XLEN +: XLEN] = 32'h0000_00AA;
      cycle(1'b1, 3'd2, din, 1'b1, 1'b0);
      check("first_out", o_muxnx1_out, 32'h0000_00AA);

      // Streaming at full rate.
      for (int k = 0; k < NUM_IN; k++) din[k*XLEN +: XLEN] = 32'h1000 + 32'(k);
      for (int i = 0; i < 8; i++) cycle(1'b1, SEL_W'(i % 4), din, 1'b1, 1'b0);
      cycle(1'b0, 3'd0, din, 1'b1, 1'b0);

      // Back-pressure: A and B absorbed, C waits upstream.
      cycle(1'b1, 3'd0, fill_din(32'h11), 1'b0, 1'b0);
      cycle(1'b1, 3'd0, fill_din(32'h22), 1'b0, 1'b0);
      check("bp_ready", 32'(o_muxnx1_ready), 32'h0);
      for (int i = 0; i < 2; i++) cycle(1'b1, 3'd0, fill_din(32'h33), 1'b0, 1'b0);
      for (int i = 0; i < 2; i++) cycle(1'b1, 3'd0, fill_din(32'h33), 1'b1, 1'b0);
      check("bp_c", o_muxnx1_out, 32'h33);
      for (int i = 0; i < 2; i++) cycle(1'b0, 3'd0, '0, 1'b1, 1'b0);

      // Out-of-range select then a valid one.
      cycle(1'b1, 3'd6, fill_din(32'hFFFF_FFFF), 1'b1, 1'b0);
      check("oor_err", 32'(o_muxnx1_err), 32'h1);
      check("oor_out", o_muxnx1_out, 32'h0);
      din = fill_din(32'hFFFF_FFFF);
      din[4*XLEN +: XLEN] = 32'h4444_0004;
      cycle(1'b1, 3'd4, din, 1'b1, 1'b0);
      check("in4_out", o_muxnx1_out, 32'h4444_0004);
      cycle(1'b1, 3'd7, rand_din(), 1'b1, 1'b0);

      // Flush from TWO and from ONE with a beat offered in the same cycle.
      cycle(1'b1, 3'd1, rand_din(), 1'b0, 1'b0);
      cycle(1'b1, 3'd2, rand_din(), 1'b0, 1'b0);
      cycle(1'b1, 3'd3, rand_din(), 1'b0, 1'b1);
      check("flush_valid", 32'(o_muxnx1_valid), 32'h0);
      cycle(1'b1, 3'd0, rand_din(), 1'b0, 1'b0);
      cycle(1'b1, 3'd4, rand_din(), 1'b1, 1'b1);
      cycle(1'b1, 3'd2, rand_din(), 1'b1, 1'b0);
      cycle(1'b0, 3'd0, '0, 1'b1, 1'b0);

      // Random traffic.
      for (int i = 0; i < 10000; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), SEL_W'($urandom), rand_din(),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
